// File: rtl/puf_challenge_collector_if.sv
// Bus between the arbiter-PUF challenge/response collector and its environment.
// The master side is the collector. The slave side is the PUF core plus the downstream consumer.
interface puf_challenge_collector_if #(
    parameter int C_LENGTH  = 8,
    parameter int RESP_BITS = 8
);
    logic                 istart;
    logic [C_LENGTH-1:0]  iseed;
    logic [C_LENGTH-1:0]  ochallenge;
    logic                 opulse;
    logic                 iresponse;
    logic [RESP_BITS-1:0] oresponse_byte;
    logic                 ovalid;
    logic                 iready;
    logic                 obusy;
    logic [RESP_BITS-1:0] ounstable;

    modport master (
        input  istart, iseed, iresponse, iready,
        output ochallenge, opulse, oresponse_byte, ovalid, obusy, ounstable
    );

    modport slave (
        output istart, iseed, iresponse, iready,
        input  ochallenge, opulse, oresponse_byte, ovalid, obusy, ounstable
    );
endinterface

// File: rtl/puf_challenge_collector.sv
// Arbiter-PUF sequencer and response collector.
// For each challenge the block fires VOTES race pulses. Each pulse is framed by SETTLE low
// cycles and SETTLE high cycles. The block samples the synchronised response after each
// pulse and majority-votes the samples into one bit. RESP_BITS voted bits are packed into
// one word, which is handed downstream with a valid/ready handshake.
// Challenges come from an 8-bit LFSR, so C_LENGTH must be 8.
// Optional feature: define PUF_STABILITY_EN to report a per-bit mask of non-unanimous votes
// on ounstable. Without it, ounstable is tied to zero.
module puf_challenge_collector #(
    parameter int C_LENGTH  = 8,
    parameter int VOTES     = 5,
    parameter int SETTLE    = 4,
    parameter int RESP_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    puf_challenge_collector_if.master bus
);

    localparam int OC_W = $clog2(VOTES + 1);
    localparam int PH_W = $clog2(SETTLE);
    localparam int BI_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [OC_W-1:0] VOTE_LAST = OC_W'(VOTES - 1);
    localparam logic [OC_W-1:0] VOTE_ALL  = OC_W'(VOTES);
    localparam logic [OC_W-1:0] VOTE_HALF = OC_W'(VOTES / 2);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SETTLE - 1);
    localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        SAMPLE,
        DECIDE,
        OUT
    } state_t;

    state_t state, state_nxt;

    logic                 resp_p0;
    logic                 resp_s;
    logic [PH_W-1:0]      phase_cnt;
    logic [OC_W-1:0]      vote_idx;
    logic [OC_W-1:0]      ones_cnt;
    logic [BI_W-1:0]      bit_idx;
    logic [RESP_BITS-1:0] shreg;
    logic [RESP_BITS-1:0] shreg_w;
    logic                 phase_done;
    logic                 vote_done;
    logic                 bit_done;

    // A zero seed would lock the LFSR at zero, so it is replaced by 0x01.
    function automatic logic [C_LENGTH-1:0] seed_fix(input logic [C_LENGTH-1:0] s);
        return (s == '0) ? C_LENGTH'(1) : s;
    endfunction

    function automatic logic [C_LENGTH-1:0] lfsr_next(input logic [C_LENGTH-1:0] c);
        return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

    function automatic logic majority(input logic [OC_W-1:0] ones);
        return ones > VOTE_HALF;
    endfunction

    assign phase_done = (phase_cnt == PH_LAST);
    assign vote_done  = (vote_idx == VOTE_LAST);
    assign bit_done   = (bit_idx == BIT_LAST);

    // Two-flop synchroniser for the asynchronous PUF response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_p0 <= 1'b0;
            resp_s  <= 1'b0;
        end else begin
            resp_p0 <= bus.iresponse;
            resp_s  <= resp_p0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic, plus the response word with the current voted bit merged in.
    always_comb begin
        state_nxt = state;
        shreg_w   = shreg;
        shreg_w[bit_idx] = majority(ones_cnt);
        case (state)
            IDLE:    if (bus.istart) state_nxt = ARM;
            ARM:     if (phase_done) state_nxt = FIRE;
            FIRE:    if (phase_done) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = vote_done ? DECIDE : ARM;
            DECIDE:  state_nxt = bit_done ? OUT : ARM;
            OUT:     if (bus.iready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Phase timer that sets the length of the low and high halves of each race pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
        end else if ((state == ARM) || (state == FIRE)) begin
            phase_cnt <= phase_done ? '0 : phase_cnt + 1'b1;
        end else begin
            phase_cnt <= '0;
        end
    end

    // Pulse and busy outputs, registered from the next state so they align with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.opulse <= 1'b0;
            bus.obusy  <= 1'b0;
        end else begin
            bus.opulse <= (state_nxt == FIRE);
            bus.obusy  <= (state_nxt != IDLE);
        end
    end

    // Challenge, vote accumulation, bit packing and the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ochallenge     <= '0;
            bus.oresponse_byte <= '0;
            bus.ovalid         <= 1'b0;
            vote_idx           <= '0;
            ones_cnt           <= '0;
            bit_idx            <= '0;
            shreg              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.istart) begin
                        bus.ochallenge <= seed_fix(bus.iseed);
                        vote_idx       <= '0;
                        ones_cnt       <= '0;
                        bit_idx        <= '0;
                        shreg          <= '0;
                    end
                end
                SAMPLE: begin
                    ones_cnt <= ones_cnt + OC_W'(resp_s);
                    vote_idx <= vote_idx + 1'b1;
                end
                DECIDE: begin
                    shreg          <= shreg_w;
                    bus.ochallenge <= lfsr_next(bus.ochallenge);
                    ones_cnt       <= '0;
                    vote_idx       <= '0;
                    bit_idx        <= bit_done ? '0 : bit_idx + 1'b1;
                    if (bit_done) begin
                        bus.oresponse_byte <= shreg_w;
                        bus.ovalid         <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.iready) bus.ovalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef PUF_STABILITY_EN
    logic [RESP_BITS-1:0] unst_sh;
    logic [RESP_BITS-1:0] unst_w;

    // Unstable-bit mask with the current bit merged in: set when the votes were split.
    always_comb begin
        unst_w = unst_sh;
        unst_w[bit_idx] = (ones_cnt != '0) && (ones_cnt != VOTE_ALL);
    end

    // The mask accumulates during the run and is published together with the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unst_sh       <= '0;
            bus.ounstable <= '0;
        end else if ((state == IDLE) && bus.istart) begin
            unst_sh       <= '0;
            bus.ounstable <= '0;
        end else if (state == DECIDE) begin
            unst_sh <= unst_w;
            if (bit_done) bus.ounstable <= unst_w;
        end
    end
`else
    assign bus.ounstable = '0;
`endif

endmodule

// File: tb/tb_puf_challenge_collector.sv
// Directed testbench for puf_challenge_collector.
// One instance uses the default parameters. A second instance uses VOTES=1 and SETTLE=3.
module tb_puf_challenge_collector;

    logic clk;
    logic rst;

    puf_challenge_collector_if #(.C_LENGTH(8), .RESP_BITS(8)) bus ();
    puf_challenge_collector_if #(.C_LENGTH(8), .RESP_BITS(8)) bus2 ();

    puf_challenge_collector u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    puf_challenge_collector #(.VOTES(1), .SETTLE(3)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // PUF model: 0 = always 1, 1 = ochallenge[0], 2 = noisy bit on challenge 0x08.
    int   mode = 0;
    int   prun = 0;
    int   pcount = 0;
    logic pulse_q = 1'b0;
    logic [7:0] ch_log [0:511];
    logic [7:0] exp_ch [0:7];
    int   vk;

    // Count race pulses and record the challenge seen at each pulse.
    always @(negedge clk) begin
        if (bus.opulse && !pulse_q) begin
            ch_log[pcount % 512] <= bus.ochallenge;
            pcount <= pcount + 1;
        end
        pulse_q <= bus.opulse;
    end

    always_comb begin
        vk = ((pcount - prun - 1) % 5) + 1;
        case (mode)
            0:       bus.iresponse = 1'b1;
            1:       bus.iresponse = bus.ochallenge[0];
            default: bus.iresponse = (bus.ochallenge == 8'h08) && ((vk == 1) || (vk == 3));
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] seed);
        bus.iseed  = seed;
        bus.istart = 1'b1;
        @(posedge clk); #1;
        bus.istart = 1'b0;
        prun = pcount;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.ovalid && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_challenges(input string tag);
        for (int k = 0; k < 8; k++)
            chk(tag, ch_log[(prun + 5 * k) % 512], exp_ch[k]);
    endtask

    int cyc;
    logic [7:0] ch2;
    logic [7:0] unst_exp;

    initial begin
        exp_ch[0] = 8'h01; exp_ch[1] = 8'h02; exp_ch[2] = 8'h04; exp_ch[3] = 8'h08;
        exp_ch[4] = 8'h11; exp_ch[5] = 8'h23; exp_ch[6] = 8'h47; exp_ch[7] = 8'h8E;
`ifdef PUF_STABILITY_EN
        unst_exp = 8'h08;
`else
        unst_exp = 8'h00;
`endif
        rst = 1'b1;
        bus.istart = 1'b0;  bus.iseed = 8'h00;  bus.iready = 1'b0;
        bus2.istart = 1'b0; bus2.iseed = 8'h00; bus2.iready = 1'b1; bus2.iresponse = 1'b1;
        ch2 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovalid", bus.ovalid, 0);
        chk("rst_obusy", bus.obusy, 0);
        chk("rst_opulse", bus.opulse, 0);
        chk("rst_chal", bus.ochallenge, 0);
        chk("rst_byte", bus.oresponse_byte, 0);
        chk("rst_unst", bus.ounstable, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Scenario 1: response tied high.
        mode = 0; bus.iready = 1'b1;
        start_run(8'h01);
        chk("s1_busy", bus.obusy, 1);
        wait_valid(cyc);
        chk("s1_latency", cyc, 368);
        chk("s1_byte", bus.oresponse_byte, 8'hFF);
        chk("s1_unst", bus.ounstable, 0);
        chk("s1_pulses", pcount - prun, 40);
        check_challenges("s1_chal");
        @(posedge clk); #1;
        chk("s1_valid_drop", bus.ovalid, 0);
        chk("s1_idle", bus.obusy, 0);

        // Scenario 2: response follows challenge bit 0.
        mode = 1;
        start_run(8'h01);
        wait_valid(cyc);
        chk("s2_latency", cyc, 368);
        chk("s2_byte", bus.oresponse_byte, 8'h71);
        chk("s2_unst", bus.ounstable, 0);
        @(posedge clk); #1;

        // Scenario 3: split votes on the bit-3 challenge.
        mode = 2;
        start_run(8'h01);
        wait_valid(cyc);
        chk("s3_byte", bus.oresponse_byte, 8'h00);
        chk("s3_unst", bus.ounstable, unst_exp);
        @(posedge clk); #1;

        // Scenario 4: backpressure in OUT; start requests are ignored.
        mode = 0; bus.iready = 1'b0;
        start_run(8'h01);
        wait_valid(cyc);
        chk("s4_latency", cyc, 368);
        for (int i = 0; i < 20; i++) begin
            bus.istart = i[0];
            bus.iseed  = 8'h55;
            @(posedge clk); #1;
            chk("s4_hold_valid", bus.ovalid, 1);
            chk("s4_hold_byte", bus.oresponse_byte, 8'hFF);
            chk("s4_hold_pulse", bus.opulse, 0);
        end
        bus.istart = 1'b0;
        bus.iready = 1'b1;
        @(posedge clk); #1;
        chk("s4_valid_drop", bus.ovalid, 0);
        chk("s4_idle", bus.obusy, 0);

        // Scenario 5: asynchronous reset during FIRE of bit 4, then restart with seed 0.
        start_run(8'h01);
        repeat (188) @(posedge clk);
        #1;
        chk("s5_in_fire", bus.opulse, 1);
        chk("s5_bit4_chal", bus.ochallenge, 8'h11);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_pulse", bus.opulse, 0);
        chk("s5_rst_valid", bus.ovalid, 0);
        chk("s5_rst_busy", bus.obusy, 0);
        chk("s5_rst_chal", bus.ochallenge, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_run(8'h00);
        chk("s5_seed_fix", bus.ochallenge, 8'h01);
        wait_valid(cyc);
        chk("s5_latency", cyc, 368);
        chk("s5_byte", bus.oresponse_byte, 8'hFF);
        chk("s5_pulses", pcount - prun, 40);
        check_challenges("s5_chal");
        @(posedge clk); #1;

        // Scenario 6: VOTES=1, SETTLE=3 instance, seed 0x8E.
        bus2.iseed  = 8'h8E;
        bus2.istart = 1'b1;
        @(posedge clk); #1;
        bus2.istart = 1'b0;
        chk("s6_first_chal", bus2.ochallenge, 8'h8E);
        cyc = 0;
        while (!bus2.ovalid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 8) ch2 = bus2.ochallenge;
        end
        chk("s6_latency", cyc, 64);
        chk("s6_second_chal", ch2, 8'h1C);
        chk("s6_byte", bus2.oresponse_byte, 8'hFF);
        @(posedge clk); #1;
        chk("s6_valid_drop", bus2.ovalid, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
